// File: rtl/mult_div_seq_if.sv
// Handshake and result bundle between the controller and the iterative MULT/DIV unit.
// The master issues operations; the slave (the unit) reports busy/done and the HI/LO pair.
interface mult_div_seq_if #(
   parameter int WIDTH = 32
);
   logic             start_mult;
   logic             start_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start_mult, start_div, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start_mult, start_div, a, b,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide producing HI/LO: radix-2 Booth multiply and restoring
// divide on magnitudes share one (WIDTH+1)-bit add/subtract datapath.
module mult_div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          reset,
   mult_div_seq_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
      return ~x + ONE_W;
   endfunction

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? neg_val(x) : x;
   endfunction

   state_t           state_r, state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH:0]   acc_r;
   logic [WIDTH:0]   mcand_r;
   logic [WIDTH-1:0] q_r;
   logic             qm1_r;
   logic             op_div_r;
   logic             a_neg_r;
   logic             b_neg_r;
   logic             dz_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic             done_r;
   logic             div_zero_r;

   logic             start_s;
   logic             sub_s;
   logic             use_add_s;
   logic [WIDTH:0]   src_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   booth_s;
   logic [WIDTH:0]   acc_nx_s;
   logic [WIDTH-1:0] q_nx_s;
   logic             qm1_nx_s;
   logic [WIDTH-1:0] div_lo_s;
   logic [WIDTH-1:0] div_hi_s;

   assign start_s      = bus.start_mult | bus.start_div;
   assign bus.busy     = (state_r != ST_IDLE);
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;
   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state selection; a divide by zero skips the iteration phase.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               if (!bus.start_mult && (bus.b == {WIDTH{1'b0}})) begin
                  state_nx_s = ST_FIN;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == LAST_CNT) begin
               state_nx_s = ST_FIN;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_FIN:  state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Shared add/subtract step: Booth uses acc directly, divide trial-subtracts from the shifted remainder.
   always_comb begin
      src_s     = op_div_r ? {acc_r[WIDTH-1:0], q_r[WIDTH-1]} : acc_r;
      sub_s     = op_div_r | (q_r[0] & ~qm1_r);
      use_add_s = op_div_r | (q_r[0] ^ qm1_r);
      sum_s     = src_s + (sub_s ? ~mcand_r : mcand_r) + {{WIDTH{1'b0}}, sub_s};
      booth_s   = use_add_s ? sum_s : acc_r;
      if (op_div_r) begin
         acc_nx_s = sum_s[WIDTH] ? src_s : sum_s;
         q_nx_s   = {q_r[WIDTH-2:0], ~sum_s[WIDTH]};
         qm1_nx_s = 1'b0;
      end else begin
         acc_nx_s = {booth_s[WIDTH], booth_s[WIDTH:1]};
         q_nx_s   = {booth_s[0], q_r[WIDTH-1:1]};
         qm1_nx_s = q_r[0];
      end
      div_lo_s = (a_neg_r ^ b_neg_r) ? neg_val(q_r) : q_r;
      div_hi_s = a_neg_r ? neg_val(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
   end

   // Operand capture, iteration, and result/flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r      <= {CNT_W{1'b0}};
         acc_r      <= {(WIDTH+1){1'b0}};
         mcand_r    <= {(WIDTH+1){1'b0}};
         q_r        <= {WIDTH{1'b0}};
         qm1_r      <= 1'b0;
         op_div_r   <= 1'b0;
         a_neg_r    <= 1'b0;
         b_neg_r    <= 1'b0;
         dz_r       <= 1'b0;
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         done_r     <= (state_r == ST_FIN);
         div_zero_r <= (state_r == ST_FIN) & dz_r;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  op_div_r <= ~bus.start_mult;
                  cnt_r    <= {CNT_W{1'b0}};
                  acc_r    <= {(WIDTH+1){1'b0}};
                  qm1_r    <= 1'b0;
                  a_neg_r  <= bus.a[WIDTH-1];
                  b_neg_r  <= bus.b[WIDTH-1];
                  dz_r     <= ~bus.start_mult & (bus.b == {WIDTH{1'b0}});
                  if (bus.start_mult) begin
                     q_r     <= bus.b;
                     mcand_r <= {bus.a[WIDTH-1], bus.a};
                  end else begin
                     q_r     <= abs_val(bus.a);
                     mcand_r <= {1'b0, abs_val(bus.b)};
                  end
               end
            end
            ST_RUN: begin
               acc_r <= acc_nx_s;
               q_r   <= q_nx_s;
               qm1_r <= qm1_nx_s;
               cnt_r <= cnt_r + ONE_C;
            end
            ST_FIN: begin
               if (!dz_r) begin
                  if (op_div_r) begin
                     hi_r <= div_hi_s;
                     lo_r <= div_lo_s;
                  end else begin
                     hi_r <= acc_r[WIDTH-1:0];
                     lo_r <= q_r;
                  end
               end
            end
            default: begin
               cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: a transaction-level model predicts busy/done/hi/lo every cycle,
// and hand-computed constants pin the model on each directed operation.
module tb_mult_div_seq;
   localparam int W = 32;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mult_div_seq_if #(.WIDTH(W)) bus ();

   mult_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: signed results from plain 64-bit arithmetic, timing as a cycles-remaining count.
   function automatic logic [63:0] model_mult(input logic [31:0] x, input logic [31:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
   endfunction

   function automatic logic [63:0] model_div(input logic [31:0] x, input logic [31:0] y);
      longint qv, rv;
      logic [63:0] qb, rb;
      qv = longint'($signed(x)) / longint'($signed(y));
      rv = longint'($signed(x)) % longint'($signed(y));
      qb = qv;
      rb = rv;
      return {rb[31:0], qb[31:0]};
   endfunction

   int          m_rem;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_done, m_dz, p_dz;
   logic [63:0] m_res;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_rem  <= 0;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         p_dz   <= 1'b0;
         p_hi   <= 32'd0;
         p_lo   <= 32'd0;
      end else begin
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_done <= 1'b1;
               m_dz   <= p_dz;
               if (!p_dz) begin
                  m_hi <= p_hi;
                  m_lo <= p_lo;
               end
            end
         end else if (bus.start_mult || bus.start_div) begin
            if (bus.start_mult) begin
               m_res = model_mult(bus.a, bus.b);
               p_dz  <= 1'b0;
               m_rem <= W + 1;
            end else if (bus.b == 32'd0) begin
               m_res = 64'd0;
               p_dz  <= 1'b1;
               m_rem <= 1;
            end else begin
               m_res = model_div(bus.a, bus.b);
               p_dz  <= 1'b0;
               m_rem <= W + 1;
            end
            p_hi <= m_res[63:32];
            p_lo <= m_res[31:0];
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_busy",     {31'd0, bus.busy},     {31'd0, (m_rem != 0)});
      check("cyc_done",     {31'd0, bus.done},     {31'd0, m_done});
      check("cyc_div_zero", {31'd0, bus.div_zero}, {31'd0, m_dz});
      check("cyc_hi",       bus.hi, m_hi);
      check("cyc_lo",       bus.lo, m_lo);
   end

   task automatic do_op(input logic sm, input logic sd, input logic [31:0] av,
                        input logic [31:0] bv, output int lat, output int bcnt);
      bus.start_mult = sm;
      bus.start_div  = sd;
      bus.a          = av;
      bus.b          = bv;
      @(posedge clk);
      #1;
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (!bus.done && lat < 100) begin
         if (bus.busy) bcnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 100) check("timeout", 32'd0, 32'd1);
   endtask

   int lat, bcnt, dn;
   logic [31:0] cap_hi, cap_lo;

   initial begin
      reset          = 1'b0;
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.a          = 32'd0;
      bus.b          = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, bcnt);
      check("mul1_lat", lat, 32'd33);
      check("mul1_busy_cycles", bcnt, 32'd33);
      check("mul1_hi", bus.hi, 32'hFFFF_FFFF);
      check("mul1_lo", bus.lo, 32'hFFFF_FFEB);

      @(negedge clk);
      do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
      check("mul_min_hi", bus.hi, 32'h4000_0000);
      check("mul_min_lo", bus.lo, 32'h0000_0000);

      @(negedge clk);
      do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      check("div1_lo", bus.lo, 32'hFFFF_FFFD);
      check("div1_hi", bus.hi, 32'hFFFF_FFFF);
      // Start issued in the same cycle done is high.
      do_op(1'b0, 1'b1, 32'd100, 32'd7, lat, bcnt);
      check("div2_lat", lat, 32'd33);
      check("div2_lo", bus.lo, 32'd14);
      check("div2_hi", bus.hi, 32'd2);

      @(negedge clk);
      do_op(1'b0, 1'b1, 32'd5, 32'd0, lat, bcnt);
      check("dz_lat", lat, 32'd1);
      check("dz_flag", {31'd0, bus.div_zero}, 32'd1);
      check("dz_hi", bus.hi, 32'd2);
      check("dz_lo", bus.lo, 32'd14);

      @(negedge clk);
      bus.start_div = 1'b1;
      bus.a         = 32'h8000_0000;
      bus.b         = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 bus.start_div = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus.start_div = 1'b1;
      bus.a         = 32'd9;
      bus.b         = 32'd3;
      @(posedge clk);
      #1 bus.start_div = 1'b0;
      dn     = 0;
      cap_hi = 32'hDEAD_BEEF;
      cap_lo = 32'hDEAD_BEEF;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            dn++;
            cap_hi = bus.hi;
            cap_lo = bus.lo;
         end
      end
      check("divmin_done_count", dn, 32'd1);
      check("divmin_lo", cap_lo, 32'h8000_0000);
      check("divmin_hi", cap_hi, 32'h0000_0000);

      @(negedge clk);
      do_op(1'b1, 1'b1, 32'd6, 32'd7, lat, bcnt);
      check("both_lat", lat, 32'd33);
      check("both_lo", bus.lo, 32'd42);
      check("both_hi", bus.hi, 32'd0);

      @(negedge clk);
      bus.start_mult = 1'b1;
      bus.start_div  = 1'b1;
      bus.a          = 32'd6;
      bus.b          = 32'd7;
      @(posedge clk);
      #1;
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_hi", bus.hi, 32'd0);
      check("abort_lo", bus.lo, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      dn = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) dn++;
      end
      check("abort_no_done", dn, 32'd0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
